// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types for the RV32M/RV64M multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_signed_div(input muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_core.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_core
// Description : Restoring radix-2 unsigned divider, one quotient bit/cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int c_cnt_w = $clog2(XLEN + 1);

  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    dvs_q, dvs_d;
  logic               done_q, done_d;
  logic [XLEN:0]      w_shift;
  logic [XLEN:0]      w_diff;

  // quo_q doubles as the dividend shift register; its MSB feeds the remainder
  always_comb begin
    w_shift = {rem_q, quo_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, dvs_q};
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    done_d  = 1'b0;
    if (abort_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = c_cnt_w'(XLEN);
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - c_cnt_w'(1);
      done_d = (cnt_q == c_cnt_w'(1));
      if (w_shift >= {1'b0, dvs_q}) begin
        rem_d = w_diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = w_shift[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      done_q <= done_d;
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : RV32M/RV64M multiply/divide unit with tag passthrough.
//               Define MULDIV_EARLY_OUT_EN to resolve divide-by-zero and
//               signed overflow one cycle after accept.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  import riscv_pkg::*;

  localparam int              c_mcnt_w    = 3;
  localparam logic [XLEN-1:0] c_int_min   = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e      state_q, state_d;
  muldiv_op_e         op_q, op_d;
  logic [XLEN-1:0]    a_q, a_d;
  logic [XLEN-1:0]    b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic [c_mcnt_w-1:0] mcnt_q, mcnt_d;

  muldiv_op_e         w_in_op;
  logic               w_in_signed;
  logic [XLEN-1:0]    w_in_a_mag;
  logic [XLEN-1:0]    w_in_b_mag;
  logic               w_div_start;
  logic               w_div_abort;
  logic               w_div_done;
  logic [XLEN-1:0]    w_quo;
  logic [XLEN-1:0]    w_rem;

  assign w_in_op     = muldiv_op_e'(in_op);
  assign w_in_signed = op_is_signed_div(w_in_op);
  assign w_in_a_mag  = (w_in_signed && in_a[XLEN-1]) ? -in_a : in_a;
  assign w_in_b_mag  = (w_in_signed && in_b[XLEN-1]) ? -in_b : in_b;

  muldiv_div_core #(
    .XLEN (XLEN)
  ) u_div_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (w_div_start),
    .abort_i     (w_div_abort),
    .dividend_i  (w_in_a_mag),
    .divisor_i   (w_in_b_mag),
    .done_o      (w_div_done),
    .quotient_o  (w_quo),
    .remainder_o (w_rem)
  );

  // Multiply: sign-extend each operand by its own signedness, keep 2*XLEN bits
  logic               w_a_sext;
  logic               w_b_sext;
  logic [2*XLEN-1:0]  w_prod;
  logic [XLEN-1:0]    w_mul_res;

  assign w_a_sext  = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign w_b_sext  = (op_q == OP_MULH);
  assign w_prod    = {{XLEN{w_a_sext & a_q[XLEN-1]}}, a_q} *
                     {{XLEN{w_b_sext & b_q[XLEN-1]}}, b_q};
  assign w_mul_res = (op_q == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

  // Divide sign fix-up and architectural special cases
  logic               w_div_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic               w_div_by_zero;
  logic               w_div_ovf;
  logic [XLEN-1:0]    w_q_fix;
  logic [XLEN-1:0]    w_r_fix;
  logic [XLEN-1:0]    w_div_res;

  assign w_div_signed  = op_is_signed_div(op_q);
  assign w_a_neg       = w_div_signed & a_q[XLEN-1];
  assign w_b_neg       = w_div_signed & b_q[XLEN-1];
  assign w_div_by_zero = (b_q == '0);
  assign w_div_ovf     = w_div_signed && (a_q == c_int_min) && (b_q == '1);

  always_comb begin
    w_q_fix = (w_a_neg ^ w_b_neg) ? -w_quo : w_quo;
    w_r_fix = w_a_neg ? -w_rem : w_rem;
    if (w_div_by_zero) begin
      w_q_fix = '1;
      w_r_fix = a_q;
    end else if (w_div_ovf) begin
      w_q_fix = a_q;
      w_r_fix = '0;
    end
    w_div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? w_q_fix : w_r_fix;
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    result_d    = result_q;
    mcnt_d      = mcnt_q;
    w_div_start = 1'b0;
    w_div_abort = flush;
    case (state_q)
      ST_IDLE: begin
        if (!flush && in_valid) begin
          op_d  = w_in_op;
          a_d   = in_a;
          b_d   = in_b;
          tag_d = in_tag;
          if (op_is_div(w_in_op)) begin
            state_d     = ST_DIV;
            w_div_start = 1'b1;
          end else begin
            state_d = ST_MUL;
            mcnt_d  = c_mcnt_w'(MUL_LAT - 1);
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mcnt_q == '0) begin
          state_d  = ST_DONE;
          result_d = w_mul_res;
        end else begin
          mcnt_d = mcnt_q - c_mcnt_w'(1);
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_d = ST_IDLE;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (w_div_by_zero || w_div_ovf) begin
          state_d     = ST_DONE;
          result_d    = w_div_res;
          w_div_abort = 1'b1;
        end
`endif
        else if (w_div_done) begin
          state_d  = ST_DONE;
          result_d = w_div_res;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
      mcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      mcnt_q   <= mcnt_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Directed and randomized checks of muldiv_unit against an
//               arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;
  localparam int TAG_W   = 5;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  logic             v_in_valid;
  logic             v_in_ready;
  logic [2:0]       v_in_op;
  logic [63:0]      v_in_a;
  logic [63:0]      v_in_b;
  logic [TAG_W-1:0] v_in_tag;
  logic             v_out_valid;
  logic             v_out_ready;
  logic [63:0]      v_out_result;
  logic [TAG_W-1:0] v_out_tag;
  logic             v_busy;

  int n_vec = 0;
  int n_err = 0;

  muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  muldiv_unit #(.XLEN(64), .MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .in_valid(v_in_valid), .in_ready(v_in_ready), .in_op(v_in_op),
    .in_a(v_in_a), .in_b(v_in_b), .in_tag(v_in_tag),
    .out_valid(v_out_valid), .out_ready(v_out_ready),
    .out_result(v_out_result), .out_tag(v_out_tag), .busy(v_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model from the instruction semantics
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = 64'(sa / sb); return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = 64'(sa % sb); return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op < 3'd4) return MUL_LAT;
    if (EARLY && ((b == 0) || ((op == 3'd4 || op == 3'd6) &&
                  a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return XLEN + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Entered and left at posedge+1; a request is also offered in the DONE-exit cycle
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag, input int hold);
    logic [31:0] exp_res;
    int          exp_lat;
    int          cyc;
    exp_res = ref32(op, a, b);
    exp_lat = ref_lat(op, a, b);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_tag = ~tag;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 64'(cyc), 64'(exp_lat));
    check("result", 64'(out_result), 64'(exp_res));
    check("tag", 64'(out_tag), 64'(tag));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'(1));
      check("hold_result", 64'(out_result), 64'(exp_res));
      check("hold_tag", 64'(out_tag), 64'(tag));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    in_valid  = 1'b1; in_op = 3'd0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("exit_idle", 64'({busy, out_valid, in_ready}), 64'(3'b001));
  endtask

  initial begin
    int   cyc;
    logic seen;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = 3'd0; in_a = '0; in_b = '0; in_tag = '0;
    v_in_valid = 1'b0; v_out_ready = 1'b0; v_in_op = 3'd0;
    v_in_a = '0; v_in_b = '0; v_in_tag = '0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_result", 64'(out_result), 64'(0));
    check("rst_tag", 64'(out_tag), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corner cases
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd0, 5'd5, 0);
    run_op(3'd6, 32'h0000_1234, 32'd0, 5'd6, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
    run_op(3'd0, 32'h0001_0003, 32'h0002_0005, 5'd8, 5);

    // Flush in the middle of a divide, then a multiply must complete normally
    in_valid = 1'b1; in_op = 3'd4; in_a = 32'd1000; in_b = 32'd7; in_tag = 5'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_valid", 64'(out_valid), 64'(0));
    check("flush_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("flush_no_out", 64'(seen), 64'(0));
    run_op(3'd0, 32'd12345, 32'd678, 5'd21, 0);

    // Flush beats a simultaneous request in IDLE
    flush = 1'b1; in_valid = 1'b1; in_op = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_over_accept", 64'(busy), 64'(0));

    // Flush while a result is waiting drops it
    in_valid = 1'b1; in_op = 3'd3; in_a = 32'd5; in_b = 32'd6; in_tag = 5'd11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (MUL_LAT) @(posedge clk);
    #1;
    check("pre_flush_done", 64'(out_valid), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done_drop", 64'({busy, out_valid}), 64'(2'b00));

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), TAG_W'($urandom),
             int'($urandom_range(0, 2)));
    end

    // 64-bit unsigned high multiply
    v_in_valid = 1'b1; v_in_op = 3'd3; v_in_a = '1; v_in_b = '1; v_in_tag = 5'd17;
    @(posedge clk); #1;
    v_in_valid = 1'b0;
    cyc = 0;
    while (v_out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("mulhu64_lat", 64'(cyc), 64'(MUL_LAT));
    check("mulhu64", v_out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("mulhu64_tag", 64'(v_out_tag), 64'(17));
    v_out_ready = 1'b1;
    @(posedge clk); #1;
    v_out_ready = 1'b0;

    // Reset in the middle of a divide
    in_valid = 1'b1; in_op = 3'd5; in_a = 32'hFFFF_0000; in_b = 32'd3; in_tag = 5'd30;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_result", 64'(out_result), 64'(0));
    check("midrst_tag", 64'(out_tag), 64'(0));
    check("midrst_busy", 64'({busy, out_valid}), 64'(2'b00));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    seen = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check("midrst_no_out", 64'(seen), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
